serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/sum width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand set offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in for bit 0.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port sum  output  WIDTH  registered sum.
REQ-012 SHALL have port cout  output  1  registered carry-out of the MSB.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid=1, capture a, b, cin into shift/carry registers, clear bit counter, go to RUN.
REQ-015 RUN: each cycle SHALL process one bit LSB-first via one full-adder cell: sum bit shifted in at MSB of the sum shift register, operand registers shifted right, carry register <= cell carry-out, counter +1.
REQ-016 RUN SHALL last exactly WIDTH cycles; after the bit WIDTH-1 cycle, go to DONE with cout = final carry.
REQ-017 Latency: if accepted at edge k, out_valid SHALL first be 1 after edge k+WIDTH+1... precisely: WIDTH RUN edges follow the accept edge, out_valid high from edge k+WIDTH.
REQ-018 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored and not stall or corrupt state.
REQ-019 DONE: out_valid=1; sum/cout SHALL hold stable until out_ready=1; on that edge go to IDLE.
REQ-020 New operands SHALL NOT be accepted on the same edge as the output handshake; earliest accept is the following edge.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH on sum, with cout the 2^WIDTH bit; all-ones + all-ones + cin=1 SHALL yield sum all-ones, cout=1.

Reset
REQ-022 rst=1 SHALL force IDLE, in_ready=1 on the next cycle, out_valid=0, sum=0, cout=0, counter=0, carry register=0.
REQ-023 rst asserted mid-RUN or in DONE SHALL discard the operation with no out_valid pulse.
REQ-024 rst SHALL take priority over any simultaneous in_valid or out_ready.

Configuration
REQ-025 With macro SERIAL_ADDER_OVF_EN defined, SHALL add output ovf (1 bit) = carry into MSB XOR carry out of MSB, registered and valid with out_valid, reset 0.
REQ-026 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL not exist; all other behaviour unchanged.

Structure
REQ-027 Shared package SHALL hold the FSM state typedef (IDLE/RUN/DONE, 2-bit encoding) and the default-width constant.
REQ-028 Bit counter SHALL be sized $clog2(WIDTH) bits.
REQ-029 Per-bit arithmetic SHALL be one instance of the existing gate-level full-adder cell adder (a, b, cin, sum, cout); no behavioural '+' in this block.

Verification
REQ-030 WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 -> sum=0x96, cout=0, out_valid exactly 8 edges after accept.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1; a=0x10, b=0x20 -> ovf=0.
REQ-033 out_ready held 0 for 5 cycles in DONE -> out_valid, sum, cout stable all 5 cycles; in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-034 in_valid pulsed with a=0x11 during RUN of 0x5A+0x3C -> result still 0x96, second operand set not captured.
REQ-035 rst=1 for one cycle after bit 3 of RUN -> next cycle in_ready=1, out_valid=0, sum=0; fresh 0x01+0x02 then yields 0x03.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state encoding and default width for serial_adder
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle; ovf present only with SERIAL_ADDER_OVF_EN
interface serial_adder_if #(
   parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
      , output ovf
`endif
   );

endinterface

// File: rtl/adder.sv
// rtl/adder.sv - gate-level one-bit full-adder cell
module adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic p;
   logic g;
   logic t;

   xor u_p   (p, a, b);
   xor u_s   (sum, p, cin);
   and u_g   (g, a, b);
   and u_t   (t, p, cin);
   or  u_c   (cout, g, t);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder, one bit per cycle; SERIAL_ADDER_OVF_EN adds ovf
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic             cout_q;
   logic [CW-1:0]    cnt;
   logic             fa_sum;
   logic             fa_cout;
   logic             last_bit;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q;
`endif

   adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last_bit = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sh  <= bus.a;
                  b_sh  <= bus.b;
                  carry <= bus.cin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               // After WIDTH shifts the first sum bit has reached bit 0.
               sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= fa_cout;
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  cout_q <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf_q  <= carry ^ fa_cout;
`endif
                  state  <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.sum       = sum_sh;
   assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder; checks ovf when SERIAL_ADDER_OVF_EN is defined
module tb_serial_adder;

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   serial_adder_if #(.WIDTH(8)) bus ();

   serial_adder #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endfunction

   // Monitor: every output handshake is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got sum 0x%0h, expected no output", bus.sum);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sum", 64'(bus.sum), 64'(e.sum));
            check("cout", 64'(bus.cout), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!bus.in_ready && t < 40) begin
         tick();
         t++;
      end
      if (t >= 40) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
   endtask

   task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic [7:0] es, input logic ec, input logic eo, input bit expect_out);
      exp_t e;
      wait_ready();
      bus.in_valid = 1'b1;
      bus.a        = av;
      bus.b        = bv;
      bus.cin      = cv;
      e.sum  = es;
      e.cout = ec;
      e.ovf  = eo;
      if (expect_out) exp_q.push_back(e);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!bus.out_valid && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
   endtask

   initial begin
      int n;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b1;
      rst           = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_sum", 64'(bus.sum), 64'd0);
      check("rst_cout", 64'(bus.cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("rst_ovf", 64'(bus.ovf), 64'd0);
`endif

      // First operation: latency from the accept edge must be exactly 8 edges.
      issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);
      check("run_in_ready", 64'(bus.in_ready), 64'd0);
      wait_out(n);
      check("latency", 64'(n), 64'd8);
      tick();

      issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
      issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
      issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
      issue(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
      issue(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
      wait_ready();

      // Consumer stall: result must hold for 5 cycles while out_ready is low.
      bus.out_ready = 1'b0;
      issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
      wait_out(n);
      for (int i = 0; i < 5; i++) begin
         check("stall_out_valid", 64'(bus.out_valid), 64'd1);
         check("stall_sum", 64'(bus.sum), 64'h46);
         check("stall_cout", 64'(bus.cout), 64'd0);
         check("stall_in_ready", 64'(bus.in_ready), 64'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      check("release_in_ready", 64'(bus.in_ready), 64'd1);
      check("release_out_valid", 64'(bus.out_valid), 64'd0);

      // Stray in_valid during RUN must be ignored.
      issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);
      tick();
      tick();
      bus.in_valid = 1'b1;
      bus.a        = 8'h11;
      bus.b        = 8'h11;
      tick();
      bus.in_valid = 1'b0;
      wait_out(n);
      check("stray_latency", 64'(n), 64'd5);
      tick();
      for (int i = 0; i < 3; i++) begin
         check("stray_no_second", 64'(bus.out_valid), 64'd0);
         tick();
      end

      // Reset after bit 3 of RUN discards the operation.
      issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      check("pre_rst_in_ready", 64'(bus.in_ready), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_sum", 64'(bus.sum), 64'd0);
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid) check("midrst_no_pulse", 64'(bus.out_valid), 64'd0);
         tick();
      end
      issue(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
      wait_out(n);
      tick();
      tick();

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
